// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, response causes,
// FSM states and the byte-lane enable helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_UNMAPPED = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RSP     = 2'd1,
        IO_WAIT = 2'd2,
        IO_RSP  = 2'd3
    } state_e;

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Moves the addressed byte/half of a 32-bit word down to bit 0 and extends it.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = data >> {off, 3'b000};
        case (size)
            SZ_BYTE: result = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store front end that splits CPU data accesses between a single-cycle RAM
// and a handshaked IO window, with alignment, decode and IO timeout faults.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          RAM_ADDR_W = 14,
    parameter int          IO_ADDR_W  = 8,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000,
    parameter int          IO_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_cause,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  io_en,
    output logic                  io_we,
    output logic [3:0]            io_be,
    output logic [IO_ADDR_W-1:0]  io_addr,
    output logic [31:0]           io_wdata,
    input  logic [31:0]           io_rdata,
    input  logic                  io_ready
);

    localparam logic [32:0] RAM_LIMIT = 33'd1 << (RAM_ADDR_W + 2);
    localparam logic [32:0] IO_SPAN   = 33'd1 << IO_ADDR_W;
    localparam logic [7:0]  TMO_LAST  = 8'(IO_TIMEOUT - 1);

    state_e      state, state_nxt;
    cause_e      acc_cause, r_cause;
    logic        fire, misaligned, is_ram, is_io, io_go, tmo_hit;
    logic [31:0] io_off, wdata_rep, align_src, aligned, io_data;
    logic [3:0]  lanes;
    logic [1:0]  r_size, r_off;
    logic        r_signed, r_we;
    logic [7:0]  wait_cnt;

    assign req_ready = resetb && (state != IO_WAIT);
    assign fire      = req_valid && req_ready;
    assign lanes     = lane_en(req_size, req_addr[1:0]);
    assign io_off    = req_addr - IO_BASE;
    assign is_ram    = {1'b0, req_addr} < RAM_LIMIT;
    assign is_io     = (req_addr >= IO_BASE) && ({1'b0, io_off} < IO_SPAN);
    assign tmo_hit   = (state == IO_WAIT) && !io_ready && (wait_cnt == TMO_LAST);

    // Alignment is judged before decode so a misaligned unmapped access reports cause 1.
    always_comb begin
        case (req_size)
            SZ_HALF: misaligned = req_addr[0];
            SZ_WORD: misaligned = |req_addr[1:0];
            SZ_ILL:  misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
        if (misaligned)
            acc_cause = CAUSE_MISALIGN;
        else if (!is_ram && !is_io)
            acc_cause = CAUSE_UNMAPPED;
        else
            acc_cause = CAUSE_OK;
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    assign ram_en    = fire && (acc_cause == CAUSE_OK) && is_ram;
    assign io_go     = fire && (acc_cause == CAUSE_OK) && !is_ram;
    assign ram_we    = ram_en ? (lanes & {4{req_we}}) : 4'b0000;
    assign ram_addr  = req_addr[RAM_ADDR_W+1:2];
    assign ram_wdata = wdata_rep;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IO_WAIT: state_nxt = (io_ready || wait_cnt == TMO_LAST) ? IO_RSP : IO_WAIT;
            default: begin
                if (fire)
                    state_nxt = io_go ? IO_WAIT : RSP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_size   <= 2'd0;
            r_off    <= 2'd0;
            r_signed <= 1'b0;
            r_we     <= 1'b0;
            r_cause  <= CAUSE_OK;
        end else if (fire) begin
            r_size   <= req_size;
            r_off    <= req_addr[1:0];
            r_signed <= req_signed;
            r_we     <= req_we;
            r_cause  <= acc_cause;
        end else if (tmo_hit) begin
            r_cause  <= CAUSE_TIMEOUT;
        end
    end

    // The IO bus sees a registered copy of the request, held until the access ends.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            io_en    <= 1'b0;
            io_we    <= 1'b0;
            io_be    <= 4'b0000;
            io_addr  <= '0;
            io_wdata <= 32'd0;
            io_data  <= 32'd0;
            wait_cnt <= 8'd0;
        end else if (io_go) begin
            io_en    <= 1'b1;
            io_we    <= req_we;
            io_be    <= lanes;
            io_addr  <= io_off[IO_ADDR_W-1:0];
            io_wdata <= wdata_rep;
            wait_cnt <= 8'd0;
        end else if (state == IO_WAIT) begin
            if (io_ready) begin
                io_data <= io_rdata;
                io_en   <= 1'b0;
            end else if (wait_cnt == TMO_LAST) begin
                io_en   <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign align_src = (state == IO_RSP) ? io_data : ram_rdata;

    load_align u_load_align (
        .data   (align_src),
        .size   (r_size),
        .off    (r_off),
        .sgn    (r_signed),
        .result (aligned)
    );

    assign rsp_valid = (state == RSP) || (state == IO_RSP);
    assign rsp_cause = rsp_valid ? r_cause : CAUSE_OK;
    assign rsp_rdata = (rsp_valid && r_cause == CAUSE_OK && !r_we) ? aligned : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: expected responses are queued at issue time and a
// negedge monitor retires them whenever rsp_valid is seen.
module tb_dmem_ctrl;

    localparam int RAM_ADDR_W = 14;
    localparam int IO_ADDR_W  = 8;
    localparam int IO_TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  resetb;
    logic                  req_valid, req_ready, req_we, req_signed;
    logic [31:0]           req_addr, req_wdata;
    logic [1:0]            req_size;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_cause;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata = 32'd0;
    logic                  io_en, io_we;
    logic [3:0]            io_be;
    logic [IO_ADDR_W-1:0]  io_addr;
    logic [31:0]           io_wdata, io_rdata;
    logic                  io_ready;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    logic        acc_ram_en;
    logic [3:0]  acc_ram_we;
    logic [31:0] acc_ram_wdata;
    logic [31:0] mem [0:(1<<RAM_ADDR_W)-1];

    dmem_ctrl #(
        .RAM_ADDR_W (RAM_ADDR_W),
        .IO_ADDR_W  (IO_ADDR_W),
        .IO_BASE    (32'h8000_0000),
        .IO_TIMEOUT (IO_TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_cause  (rsp_cause),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .io_en      (io_en),
        .io_we      (io_we),
        .io_be      (io_be),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ready   (io_ready)
    );

    always #5 clk = ~clk;

    // Byte-lane RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetb && rsp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rsp_unexpected actual=%h/%0d required=no response", rsp_rdata, rsp_cause);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e[33:2]);
                check("rsp_cause", {30'd0, rsp_cause}, {30'd0, mon_e[1:0]});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic [1:0] exp_c);
        req_addr   = a;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_wdata  = wd;
        req_valid  = 1'b1;
        exp_q.push_back({exp_d, exp_c});
        @(negedge clk);
        check("req_ready", {31'd0, req_ready}, 32'd1);
        acc_ram_en    = ram_en;
        acc_ram_we    = ram_we;
        acc_ram_wdata = ram_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic ram_op(input logic [31:0] a, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] wd, input logic [31:0] exp_d,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        issue(a, we, sz, sg, wd, exp_d, 2'd0);
        req_valid = 1'b0;
        check("ram_en", {31'd0, acc_ram_en}, 32'd1);
        check("ram_we", {28'd0, acc_ram_we}, {28'd0, exp_we});
        if (we) check("ram_wdata", acc_ram_wdata, exp_wdata);
        @(negedge clk);
        check("ram_latency", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_op(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] exp_c);
        issue(a, 1'b0, sz, 1'b0, 32'd0, 32'd0, exp_c);
        req_valid = 1'b0;
        check("fault_ram_en", {31'd0, acc_ram_en}, 32'd0);
        check("fault_io_en", {31'd0, io_en}, 32'd0);
        @(negedge clk);
        check("fault_latency", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic io_op(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd, input int delay,
                         input logic [31:0] rdat, input logic [7:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_d);
        issue(a, we, sz, sg, wd, exp_d, 2'd0);
        req_valid = 1'b0;
        check("io_no_ram", {31'd0, acc_ram_en}, 32'd0);
        check("io_en", {31'd0, io_en}, 32'd1);
        check("io_addr", {24'd0, io_addr}, {24'd0, exp_addr});
        check("io_we", {31'd0, io_we}, {31'd0, we});
        check("io_be", {28'd0, io_be}, {28'd0, exp_be});
        check("io_wdata", io_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            check("io_wait_ready", {31'd0, req_ready}, 32'd0);
            check("io_wait_en", {31'd0, io_en}, 32'd1);
            @(posedge clk);
            #1;
        end
        io_ready = 1'b1;
        io_rdata = rdat;
        @(posedge clk);
        #1;
        io_ready = 1'b0;
        io_rdata = 32'd0;
        check("io_en_drop", {31'd0, io_en}, 32'd0);
        @(negedge clk);
        check("io_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus;
        int n;
        // Reset behaviour, with a request already presented.
        resetb = 1'b0; req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0;
        req_size = 2'd2; req_signed = 1'b0; req_wdata = 32'd0;
        io_ready = 1'b0; io_rdata = 32'd0;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_ram_we", {28'd0, ram_we}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_io_en", {31'd0, io_en}, 32'd0);
        check("rst_io_be", {28'd0, io_be}, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
        @(posedge clk);
        #1;

        // RAM word, sub-word loads and stores.
        ram_op(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'd0, 4'b1111, 32'hDEADBEEF);
        ram_op(32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 32'hDEADBEEF, 4'b0000, 32'd0);
        ram_op(32'h10, 1'b1, 2'd2, 1'b0, 32'h80FF0000, 32'd0, 4'b1111, 32'h80FF0000);
        ram_op(32'h13, 1'b0, 2'd0, 1'b1, 32'd0, 32'hFFFFFF80, 4'b0000, 32'd0);
        ram_op(32'h12, 1'b0, 2'd1, 1'b0, 32'd0, 32'h000080FF, 4'b0000, 32'd0);
        ram_op(32'h12, 1'b0, 2'd1, 1'b1, 32'd0, 32'hFFFF80FF, 4'b0000, 32'd0);
        ram_op(32'h12, 1'b0, 2'd0, 1'b0, 32'd0, 32'h000000FF, 4'b0000, 32'd0);
        ram_op(32'h20, 1'b1, 2'd2, 1'b0, 32'h0, 32'd0, 4'b1111, 32'h0);
        ram_op(32'h21, 1'b1, 2'd0, 1'b0, 32'h000000A5, 32'd0, 4'b0010, 32'hA5A5A5A5);
        ram_op(32'h22, 1'b1, 2'd1, 1'b0, 32'h00001234, 32'd0, 4'b1100, 32'h12341234);
        ram_op(32'h20, 1'b0, 2'd2, 1'b0, 32'd0, 32'h1234A500, 4'b0000, 32'd0);

        // Back-to-back loads, one per cycle.
        issue(32'h10, 1'b0, 2'd2, 1'b0, 32'd0, 32'h80FF0000, 2'd0);
        issue(32'h20, 1'b0, 2'd2, 1'b0, 32'd0, 32'h1234A500, 2'd0);
        check("b2b_ram_en", {31'd0, acc_ram_en}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;

        // IO accesses.
        io_op(32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'd0, 3, 32'h0000_1234, 8'h04, 4'b1111, 32'd0, 32'h0000_1234);
        io_op(32'h8000_0010, 1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 1, 32'd0, 8'h10, 4'b1111, 32'hCAFEF00D, 32'd0);
        io_op(32'h8000_0007, 1'b0, 2'd0, 1'b1, 32'd0, 0, 32'h7F00_0000, 8'h07, 4'b1000, 32'd0, 32'h0000_007F);

        // IO timeout.
        issue(32'h8000_0008, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 2'd3);
        req_valid = 1'b0;
        n = 0;
        while (io_en && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("tmo_cycles", n, IO_TIMEOUT);
        @(negedge clk);
        check("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Faults.
        fault_op(32'h0000_0001, 2'd1, 2'd1);
        fault_op(32'h4000_0000, 2'd2, 2'd2);
        fault_op(32'h0000_0000, 2'd3, 2'd1);
        fault_op(32'h8000_0100, 2'd2, 2'd2);
        fault_op(32'h4000_0001, 2'd1, 2'd1);

        // Reset during an IO wait aborts it silently.
        issue(32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 2'd0);
        req_valid = 1'b0;
        check("abort_io_en", {31'd0, io_en}, 32'd1);
        @(posedge clk);
        #1;
        resetb = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("abort_io_en_drop", {31'd0, io_en}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_rsp_valid2", {31'd0, rsp_valid}, 32'd0);
        resetb = 1'b1;
        @(posedge clk);
        #1;
        ram_op(32'h30, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'd0, 4'b1111, 32'h11223344);
        ram_op(32'h30, 1'b0, 2'd2, 1'b0, 32'd0, 32'h11223344, 4'b0000, 32'd0);
    endtask

    task automatic checkOutput;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter RAM_ADDR_W, 14, RAM word-address bits (RAM spans bytes 0 .. 2^(RAM_ADDR_W+2)-1).
REQ-002 Parameter IO_ADDR_W, 8, IO byte-address bits.
REQ-003 Parameter IO_BASE, 32'h8000_0000, IO window base; window is IO_BASE .. IO_BASE+2^IO_ADDR_W-1.
REQ-004 Parameter IO_TIMEOUT, 15, maximum IO wait cycles before a timeout fault; legal range 1..255.
REQ-005 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1, clock, rising edge.
REQ-007 Port resetb, input, 1, asynchronous active-low reset.
REQ-008 Port req_valid in 1, req_ready out 1: request handshake; a transfer occurs when both are high on a clk edge.
REQ-009 Port req_addr in 32, req_we in 1, req_size in 2 (0 byte, 1 half, 2 word, 3 illegal), req_signed in 1, req_wdata in 32 (right-aligned).
REQ-010 Port rsp_valid out 1, rsp_rdata out 32, rsp_cause out 2 (0 ok, 1 misaligned/illegal, 2 unmapped, 3 IO timeout).
REQ-011 Port ram_en out 1, ram_we out 4 (byte lanes), ram_addr out RAM_ADDR_W, ram_wdata out 32, ram_rdata in 32 (one-cycle read latency).
REQ-012 Port io_en out 1, io_we out 1, io_be out 4, io_addr out IO_ADDR_W, io_wdata out 32, io_rdata in 32, io_ready in 1.

Function
REQ-013 Decode: RAM if req_addr < 2^(RAM_ADDR_W+2); IO if req_addr within the IO window; otherwise unmapped.
REQ-014 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 3; checked before decode, so cause 1 takes priority over cause 2.
REQ-015 Lane enables: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
REQ-016 Write data: byte replicated on all four lanes, half on both halves, word passed through.
REQ-017 Load data: the selected lane(s) shifted to bit 0, sign- or zero-extended per the registered req_signed.
REQ-018 FSM states: IDLE, RSP, IO_WAIT, IO_RSP; req_ready=1 in IDLE, RSP and IO_RSP; req_ready=0 in IO_WAIT.
REQ-019 RAM accept: ram_en=1, ram_we=lanes&{4{req_we}}, ram_addr=addr[RAM_ADDR_W+1:2] are driven combinationally in the accept cycle; go to RSP.
REQ-020 RSP: rsp_valid=1 for exactly one cycle with aligned ram_rdata (stores: rsp_rdata=0); back-to-back RAM requests sustain one per cycle.
REQ-021 Fault accept (cause 1 or 2): no RAM or IO enable asserted; next cycle RSP with rsp_cause set and rsp_rdata=0.
REQ-022 IO accept: next cycle io_en=1 with io_addr=addr-IO_BASE, io_we, io_be and io_wdata registered; enter IO_WAIT.
REQ-023 IO_WAIT: io_* outputs held stable; on the first cycle io_ready=1, capture io_rdata, drop io_en next cycle, and enter IO_RSP.
REQ-024 Timeout: a wait counter starts at 0 on IO_WAIT entry; if io_ready is still 0 after IO_TIMEOUT cycles, drop io_en and enter IO_RSP with cause 3.
REQ-025 IO_RSP: rsp_valid=1 for one cycle with the aligned captured data (stores: 0).
REQ-026 The response side has no backpressure; the consumer SHALL always accept rsp_valid.
REQ-027 A new request accepted in RSP or IO_RSP follows REQ-019/021/022 in the same cycle as the current response.

Reset
REQ-028 With resetb low, all of the following SHALL hold asynchronously: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_cause=0, io_en=0, io_we=0, io_be=0, io_addr=0, io_wdata=0, wait counter=0.
REQ-029 ram_en=0 and ram_we=0 while resetb is low; req_ready=0 while resetb is low.
REQ-030 Reset asserted mid-IO drops io_en immediately; no response is issued for the aborted transfer.

Structure
REQ-031 Package dmem_pkg holds the size encoding, cause encoding, FSM state type and the lane-enable function.
REQ-032 One sub-module, load_align (combinational lane select and extend), instantiated once.

Verification
REQ-033 LW 0x10 after SW 0x10=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, cause 0, latency 1 cycle.
REQ-034 LB signed 0x13 over word 0x80FF0000 -> 0xFFFFFF80; LHU 0x12 -> 0x000080FF.
REQ-035 SB 0x21=0xA5 -> ram_we=4'b0010, ram_wdata=0xA5A5A5A5.
REQ-036 LW 0x8000_0004, io_ready high after 3 cycles, io_rdata=0x1234 -> rsp 0x1234; req_ready=0 during the wait.
REQ-037 IO read with io_ready held low -> cause 3 after IO_TIMEOUT cycles; LH 0x01 -> cause 1; LW 0x4000_0000 -> cause 2; no ram_en or io_en asserted on the fault cases.
REQ-038 resetb pulsed low during IO_WAIT -> io_en=0 immediately, no rsp_valid; the next RAM request completes normally.
